// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg: full-adder helper functions and shared constants for the
// bit-serial adder slice.
package serial_adder_pkg;

    localparam logic CARRY_CLR = 1'b0;

    function automatic logic fa_sum(input logic a, input logic b, input logic c);
        return a ^ b ^ c;
    endfunction

    function automatic logic fa_carry(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/serial_adder_full_adder.sv
// full_adder: purely combinational one-bit full adder used as the datapath
// stage of serial_adder.
module full_adder
    import serial_adder_pkg::*;
(
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    // Sum and majority carry of the three input bits
    always_comb begin
        sum  = fa_sum(a, b, cin);
        cout = fa_carry(a, b, cin);
    end

endmodule

// File: rtl/serial_adder.sv
// serial_adder: bit-serial adder, one bit of A and B per clock, LSB first.
// A registered full-adder stage; the carry flop links successive bits.
// Optional embedded checks: define SERIAL_ADDER_ASSERT_EN to compile SVA.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter logic CARRY_RST = 1'b0
) (
    input  logic a,
    input  logic b,
    input  logic clock,
    input  logic reset,
    output logic s,
    output logic cout
);

    logic c;
    logic s_q;
    logic sum_d;
    logic carry_d;

    full_adder u_fa (
        .a    (a),
        .b    (b),
        .cin  (c),
        .sum  (sum_d),
        .cout (carry_d)
    );

    // Carry and sum flops; reset aborts the current word and wins over a/b
    always_ff @(posedge clock) begin
        if (reset) begin
            c   <= CARRY_RST;
            s_q <= CARRY_CLR;
        end else begin
            c   <= carry_d;
            s_q <= sum_d;
        end
    end

    // Outputs come straight from flops, no combinational path from a/b
    always_comb begin
        s    = s_q;
        cout = c;
    end

`ifdef SERIAL_ADDER_ASSERT_EN
    logic past_valid;

    // Marks that at least one edge has elapsed so $past is meaningful
    always_ff @(posedge clock) begin
        past_valid <= 1'b1;
    end

    a_reset_state : assert property (@(posedge clock)
        past_valid && $past(reset) |-> (s == 1'b0) && (cout == CARRY_RST))
    else $error("serial_adder reset: s=%b cout=%b exp cout=%b", s, cout, CARRY_RST);

    a_sum : assert property (@(posedge clock) disable iff (reset)
        past_valid && !$past(reset) |-> s == fa_sum($past(a), $past(b), $past(cout)))
    else $error("serial_adder sum: a=%b b=%b c=%b s=%b cout=%b",
                $past(a), $past(b), $past(cout), s, cout);

    a_carry : assert property (@(posedge clock) disable iff (reset)
        past_valid && !$past(reset) |-> cout == fa_carry($past(a), $past(b), $past(cout)))
    else $error("serial_adder carry: a=%b b=%b c=%b s=%b cout=%b",
                $past(a), $past(b), $past(cout), s, cout);
`endif

endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: directed vector table plus hand-written multi-cycle
// sequences and a random stream checked against a bit-level model.
module tb_serial_adder;

    logic a;
    logic b;
    logic clock;
    logic reset;
    logic s;
    logic cout;

    int checks   = 0;
    int failures = 0;

    serial_adder #(.CARRY_RST(1'b0)) dut (
        .a     (a),
        .b     (b),
        .clock (clock),
        .reset (reset),
        .s     (s),
        .cout  (cout)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic a;
        logic b;
        logic cin;
        logic exp_s;
        logic exp_cout;
    } vec_t;

    vec_t vecs[8];

    // Drive one input pair for one edge, then settle past the edge
    task automatic cycle(input logic ai, input logic bi, input logic ri);
        a     = ai;
        b     = bi;
        reset = ri;
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string name, input logic es, input logic ec);
        checks++;
        if (s !== es || cout !== ec) begin
            failures++;
            $display("FAIL %s: s=%b cout=%b expected s=%b cout=%b", name, s, cout, es, ec);
        end
    endtask

    initial begin
        logic ms;
        logic mc;
        logic ra;
        logic rb;
        logic rr;
        logic wa[4];
        logic wb[4];
        logic ws[4];
        logic wc[4];

        vecs[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[2] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[3] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[4] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        vecs[6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        vecs[7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1};

        a = 1'b0;
        b = 1'b0;
        reset = 1'b1;

        // 1) reset with a=b=1 still clears state
        cycle(1'b1, 1'b1, 1'b1);
        check("reset", 1'b0, 1'b0);

        // 2,3) single-bit table, carry-in preloaded by a 1+1 bit
        for (int unsigned i = 0; i < 8; i++) begin
            cycle(1'b1, 1'b0, 1'b1);
            if (vecs[i].cin) begin
                cycle(1'b1, 1'b1, 1'b0);
                check($sformatf("preload%0d", i), 1'b0, 1'b1);
            end
            cycle(vecs[i].a, vecs[i].b, 1'b0);
            check($sformatf("vec%0d", i), vecs[i].exp_s, vecs[i].exp_cout);
        end

        // 4) 0b1011 + 0b0110 LSB first = 17
        wa = '{1'b1, 1'b1, 1'b0, 1'b1};
        wb = '{1'b0, 1'b1, 1'b1, 1'b0};
        ws = '{1'b1, 1'b0, 1'b0, 1'b0};
        wc = '{1'b0, 1'b1, 1'b1, 1'b1};
        cycle(1'b0, 1'b0, 1'b1);
        for (int unsigned i = 0; i < 4; i++) begin
            cycle(wa[i], wb[i], 1'b0);
            check($sformatf("word_bit%0d", i), ws[i], wc[i]);
        end

        // 5) reset in the middle of a carrying chain
        cycle(1'b0, 1'b0, 1'b1);
        cycle(1'b1, 1'b1, 1'b0);
        check("mid_bit0", 1'b0, 1'b1);
        cycle(1'b1, 1'b1, 1'b0);
        check("mid_bit1", 1'b1, 1'b1);
        cycle(1'b1, 1'b1, 1'b1);
        check("mid_reset", 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0);
        check("mid_after", 1'b0, 1'b0);

        // 6) random a/b/reset stream against a bit-level model
        cycle(1'b0, 1'b0, 1'b1);
        ms = 1'b0;
        mc = 1'b0;
        for (int unsigned i = 0; i < 1000; i++) begin
            ra = 1'($urandom_range(1));
            rb = 1'($urandom_range(1));
            rr = ($urandom_range(19) == 0);
            if (rr) begin
                ms = 1'b0;
                mc = 1'b0;
            end else begin
                ms = ra ^ rb ^ mc;
                mc = (ra & rb) | (ra & mc) | (rb & mc);
            end
            cycle(ra, rb, rr);
            check("random", ms, mc);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
